clockgen: RTL and testbench

//   Generates a divided square-wave clock/heartbeat (genclk) from clk, for presence/loss

---
 rtl/clockgen.sv | 151 +++++++++++++++
 tb/tb_clockgen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/clockgen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : clockgen                                                      |
// | Purpose  : Programmable divided square-wave heartbeat (genclk) with      |
// |            controlled start/stop; stops only at a full-period boundary,  |
// |            so genclk never produces a runt pulse.                        |
// | Option   : CLOCKGEN_AUTOSTART_EN - leave IDLE on the first cycle after   |
// |            reset without needing start.                                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module clockgen #(
  parameter int DWIDTH  = 16,
  parameter int DEFHALF = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [DWIDTH-1:0] half,
  input  logic              half_load,
  output logic              genclk,
  output logic              running,
  output logic              period_end
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [DWIDTH-1:0] C_ONE     = DWIDTH'(1);
  localparam logic [DWIDTH-1:0] C_DEFHALF = DWIDTH'(DEFHALF);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DWIDTH-1:0] r_cnt;
  logic [DWIDTH-1:0] w_cnt_nxt;
  logic [DWIDTH-1:0] r_half;
  logic [DWIDTH-1:0] r_pend_half;
  logic              r_pend_flag;
  logic              r_stop_pend;
  logic              w_last;
  logic              w_boundary;
  logic              w_go;
  logic [DWIDTH-1:0] w_load_val;

  // half_reg is never zero, so half_reg-1 cannot underflow
  assign w_last     = (r_cnt == (r_half - C_ONE));
  assign w_boundary = (r_state == S_LOW) && w_last;
  // a zero half-period is meaningless; clamp it to the fastest rate
  assign w_load_val = (half == '0) ? C_ONE : half;

`ifdef CLOCKGEN_AUTOSTART_EN
  logic r_auto;

  // one-shot permission to leave IDLE right after reset
  always_ff @(posedge clk) begin
    if (reset) begin
      r_auto <= 1'b1;
    end else if (r_state == S_IDLE) begin
      r_auto <= 1'b0;
    end
  end

  assign w_go = (start && !stop) || r_auto;
`else
  assign w_go = start && !stop;
`endif

  // state and half-cycle counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // next-state and counter logic; each active state lasts half_reg cycles
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_state_nxt = S_HIGH;
          w_cnt_nxt   = '0;
        end
      end
      S_HIGH: begin
        if (w_last) begin
          w_state_nxt = S_LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      S_LOW: begin
        if (w_last) begin
          w_state_nxt = r_stop_pend ? S_IDLE : S_HIGH;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // half-period, deferred-load and deferred-stop bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      r_half      <= C_DEFHALF;
      r_pend_half <= C_DEFHALF;
      r_pend_flag <= 1'b0;
      r_stop_pend <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (half_load) begin
        r_half <= w_load_val;
      end
    end else begin
      // a pending divider takes effect only at a period boundary
      if (w_boundary && r_pend_flag) begin
        r_half      <= r_pend_half;
        r_pend_flag <= 1'b0;
      end
      // a load in the boundary cycle stays pending for the following boundary
      if (half_load) begin
        r_pend_half <= w_load_val;
        r_pend_flag <= 1'b1;
      end
      if (w_boundary && r_stop_pend) begin
        r_stop_pend <= 1'b0;
      end else if (stop) begin
        r_stop_pend <= 1'b1;
      end
    end
  end

  assign genclk     = (r_state == S_HIGH);
  assign running    = (r_state != S_IDLE);
  assign period_end = w_boundary;

endmodule
`default_nettype wire

// File: tb/tb_clockgen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_clockgen                                                   |
// | Purpose  : Randomized scoreboard bench for clockgen against a            |
// |            period-level reference model.                                 |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_clockgen;

  localparam int DWIDTH  = 16;
  localparam int DEFHALF = 4;
  localparam int NCYC    = 3000;
`ifdef CLOCKGEN_AUTOSTART_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  typedef struct packed {
    logic g;
    logic r;
    logic p;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              stop;
  logic [DWIDTH-1:0] half;
  logic              half_load;
  logic              genclk;
  logic              running;
  logic              period_end;

  int checks   = 0;
  int failures = 0;

  exp_t exp_q[$];

  // reference model: a whole period is expanded into a list of cycles
  logic [1:0] m_per[$];
  int         m_half;
  int         m_pend_half;
  bit         m_pend_flag;
  bit         m_stop_pend;
  bit         m_active;
  bit         m_auto;

  clockgen #(.DWIDTH(DWIDTH), .DEFHALF(DEFHALF)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stop       (stop),
    .half       (half),
    .half_load  (half_load),
    .genclk     (genclk),
    .running    (running),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  function automatic int clamp(input logic [DWIDTH-1:0] v);
    return (v == '0) ? 1 : int'(v);
  endfunction

  task automatic gen_period();
    for (int i = 0; i < m_half; i++) m_per.push_back(2'b10);
    for (int i = 0; i < m_half; i++) m_per.push_back({1'b0, i == m_half - 1});
  endtask

  // advance the model across one clock edge and queue the expected outputs
  task automatic model_edge(input bit rs, input bit st, input bit sp,
                            input logic [DWIDTH-1:0] hv, input bit hl);
    bit   boundary;
    bit   go_idle;
    exp_t e;
    if (rs) begin
      m_active    = 1'b0;
      m_per.delete();
      m_half      = DEFHALF;
      m_pend_half = DEFHALF;
      m_pend_flag = 1'b0;
      m_stop_pend = 1'b0;
      m_auto      = AUTO;
    end else if (!m_active) begin
      if (hl) m_half = clamp(hv);
      if ((st && !sp) || m_auto) begin
        m_active = 1'b1;
        gen_period();
      end
      m_auto = 1'b0;
    end else begin
      void'(m_per.pop_front());
      boundary = (m_per.size() == 0);
      go_idle  = boundary && m_stop_pend;
      if (boundary && m_pend_flag) begin
        m_half      = m_pend_half;
        m_pend_flag = 1'b0;
      end
      if (hl) begin
        m_pend_half = clamp(hv);
        m_pend_flag = 1'b1;
      end
      if (go_idle) m_stop_pend = 1'b0;
      else if (sp) m_stop_pend = 1'b1;
      if (go_idle) m_active = 1'b0;
      else if (boundary) gen_period();
    end
    if (m_active) e = '{g: m_per[0][1], r: 1'b1, p: m_per[0][0]};
    else          e = '{g: 1'b0, r: 1'b0, p: 1'b0};
    exp_q.push_back(e);
  endtask

  // stimulus: inputs change 2 time units after each rising edge
  initial begin
    int r;
    reset = 1'b1; start = 1'b0; stop = 1'b0; half = '0; half_load = 1'b0;
    model_edge(1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #2;
      reset     = (cyc < 2) || ($urandom_range(0, 299) == 0);
      start     = ($urandom_range(0, 7) == 0);
      stop      = ($urandom_range(0, 24) == 0);
      half_load = ($urandom_range(0, 14) == 0);
      r         = int'($urandom_range(0, 19));
      half      = (r == 0) ? DWIDTH'(9) : DWIDTH'($urandom_range(0, 5));
      model_edge(reset, start, stop, half, half_load);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // monitor: outputs are presented every cycle; compare at the falling edge
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL underflow at %0t: no expected entry, required one", $time);
      end else begin
        e = exp_q.pop_front();
        checks += 2;
        if (genclk !== e.g) begin
          failures++;
          $display("FAIL genclk at %0t: got %b required %b", $time, genclk, e.g);
        end
        if (running !== e.r) begin
          failures++;
          $display("FAIL running at %0t: got %b required %b", $time, running, e.r);
        end
        if (period_end !== e.p) begin
          failures++;
          $display("FAIL period_end at %0t: got %b required %b", $time, period_end, e.p);
        end
      end
    end
  end

endmodule
`default_nettype wire
